pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning width of pc and register-data fields.
REQ-002 SHALL have parameter RADDR_W, default 5, meaning width of the destination-register index.
REQ-003 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer with registered ready_out, 0 = single-entry stage with combinational ready_out.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have port valid_in  input  1  upstream entry present.
REQ-008 SHALL have port ready_out  output  1  stage accepts an entry this cycle.
REQ-009 SHALL have port pc_in  input  XLEN  instruction address.
REQ-010 SHALL have port wb_enable_in  input  1  entry writes the register file.
REQ-011 SHALL have port rs_d_in  input  RADDR_W  destination register index.
REQ-012 SHALL have port reg_d_in  input  XLEN  write-back data.
REQ-013 SHALL have port valid_out  output  1  head entry present downstream.
REQ-014 SHALL have port ready_in  input  1  downstream accepts head entry.
REQ-015 SHALL have ports pc_out (XLEN), wb_enable_out (1), rs_d_out (RADDR_W), reg_d_out (XLEN), all outputs, carrying the head entry fields.
REQ-016 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-017 Accept: an entry SHALL be captured when valid_in && ready_out at a rising edge. Drain: the head SHALL retire when valid_out && ready_in.
REQ-018 SKID=1: the state SHALL be one of EMPTY(0), ONE(1), TWO(2). occupancy SHALL equal the state. valid_out SHALL be (state != EMPTY). ready_out SHALL be (state != TWO) and SHALL depend only on registers.
REQ-019 SKID=1 transitions: EMPTY->ONE on accept. ONE->TWO on accept without drain. ONE->EMPTY on drain without accept. ONE->ONE on accept with drain, with the new entry becoming the head. TWO->ONE on drain, with the skid entry moving to the head in that same edge.
REQ-020 SKID=0: a single entry SHALL be held. ready_out SHALL be (!valid_out || ready_in). occupancy SHALL be 0 or 1.
REQ-021 Entries SHALL leave in arrival order. No entry SHALL be duplicated or lost.
REQ-022 Latency: an entry accepted at edge N SHALL appear on the outputs after edge N when the stage was empty. The stage SHALL add no bubble under continuous valid_in and ready_in.
REQ-023 Head outputs SHALL be stable while valid_out && !ready_in.
REQ-024 wb_enable_out SHALL be (stored wb_enable && valid_out). It SHALL never be 1 while valid_out = 0.
REQ-025 flush SHALL set the state to EMPTY at the next edge and SHALL override a simultaneous accept or drain. The flushed-cycle input SHALL be discarded.
REQ-026 flush SHALL clear only the valid state and wb_enable_out. pc_out, rs_d_out and reg_d_out SHALL keep their values until the next capture.
REQ-027 All fields SHALL be captured at the full parameter width with no truncation or sign extension.

Reset
REQ-028 While reset is high, at each edge the state SHALL be EMPTY. pc_out, rs_d_out and reg_d_out SHALL be 0. wb_enable_out, valid_out and occupancy SHALL be 0.
REQ-029 reset SHALL take priority over flush, valid_in and ready_in.
REQ-030 With SKID=1, ready_out SHALL be 1 in the reset state. Inputs SHALL be ignored while reset is high.
REQ-031 Reset asserted mid-operation with 2 entries held SHALL discard both, with no write-back pulse afterwards.

Verification
REQ-032 Reset then valid_in=1, pc_in=0x100, rs_d_in=3, reg_d_in=0xDEADBEEF, wb_enable_in=1, ready_in=1 -> the next cycle shows valid_out=1, pc_out=0x100, rs_d_out=3, reg_d_out=0xDEADBEEF, wb_enable_out=1, occupancy=1.
REQ-033 SKID=1, ready_in=0, send entries A (pc 0x10) and B (pc 0x14) -> occupancy=2, ready_out=0, pc_out=0x10 held. Raise ready_in -> 0x10 then 0x14 in order, then valid_out=0.
REQ-034 Continuous valid_in and ready_in for 8 entries pc 0x0..0x1C -> 8 consecutive valid_out cycles, no bubble, order preserved.
REQ-035 occupancy=2, flush=1 with valid_in=1 in the same cycle -> next cycle occupancy=0, valid_out=0, wb_enable_out=0, ready_out=1, and the flushed input never appears.
REQ-036 occupancy=2, reset pulsed 1 cycle -> all outputs 0 and ready_out=1. SKID=0 repeat of REQ-033 -> ready_out=0 exactly while valid_out && !ready_in.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage carrying one write-back entry (pc, wb_enable,
// destination index, data). SKID=1 builds a two-entry skid buffer whose
// ready_out comes straight from the state register; SKID=0 builds a single
// entry stage whose ready_out looks through to ready_in.
module pipe_stage_skid #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int SKID    = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   input  logic               valid_in,
   output logic               ready_out,
   input  logic [XLEN-1:0]    pc_in,
   input  logic               wb_enable_in,
   input  logic [RADDR_W-1:0] rs_d_in,
   input  logic [XLEN-1:0]    reg_d_in,
   output logic               valid_out,
   input  logic               ready_in,
   output logic [XLEN-1:0]    pc_out,
   output logic               wb_enable_out,
   output logic [RADDR_W-1:0] rs_d_out,
   output logic [XLEN-1:0]    reg_d_out,
   output logic [1:0]         occupancy
);

   // The state value doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic accept;
   logic drain;
   logic load_head_in;    // head <= upstream entry
   logic load_skid_in;    // skid <= upstream entry
   logic load_head_skid;  // head <= skid entry

   logic [XLEN-1:0]    head_pc;
   logic               head_wb;
   logic [RADDR_W-1:0] head_rs;
   logic [XLEN-1:0]    head_reg;
   logic [XLEN-1:0]    skid_pc;
   logic               skid_wb;
   logic [RADDR_W-1:0] skid_rs;
   logic [XLEN-1:0]    skid_reg;

   assign valid_out = (state != EMPTY);

   // Only the ready path differs between the two builds; with SKID=0 the
   // look-through ready guarantees the state never reaches TWO.
   generate
      if (SKID != 0) begin : g_skid_ready
         assign ready_out = (state != TWO);
      end else begin : g_pass_ready
         assign ready_out = !valid_out || ready_in;
      end
   endgenerate

   assign accept = valid_in && ready_out;
   assign drain  = valid_out && ready_in;

   // State register; reset wins over everything else.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so ordering between flops cannot matter.
      if (reset) state <= EMPTY;
      else       state <= state_next;
   end

   // Next state and data-path load enables; flush overrides accept/drain.
   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise a
      // path that skips an assignment would infer a latch.
      state_next     = state;
      load_head_in   = 1'b0;
      load_skid_in   = 1'b0;
      load_head_skid = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_next   = ONE;
                  load_head_in = 1'b1;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  load_head_in = 1'b1;
               end else if (accept) begin
                  state_next   = TWO;
                  load_skid_in = 1'b1;
               end else if (drain) begin
                  state_next = EMPTY;
               end
            end
            TWO: begin
               if (drain) begin
                  state_next     = ONE;
                  load_head_skid = 1'b1;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // Entry storage; fields keep their value across drain and flush until
   // the next capture.
   always_ff @(posedge clock) begin
      // NOTE: the payload registers are reset because the head fields are
      // visible outputs that must read 0 after reset; the skid copy is
      // cleared too so no stale data can ever be promoted.
      if (reset) begin
         head_pc  <= '0;
         head_wb  <= 1'b0;
         head_rs  <= '0;
         head_reg <= '0;
         skid_pc  <= '0;
         skid_wb  <= 1'b0;
         skid_rs  <= '0;
         skid_reg <= '0;
      end else begin
         if (load_head_in) begin
            head_pc  <= pc_in;
            head_wb  <= wb_enable_in;
            head_rs  <= rs_d_in;
            head_reg <= reg_d_in;
         end else if (load_head_skid) begin
            head_pc  <= skid_pc;
            head_wb  <= skid_wb;
            head_rs  <= skid_rs;
            head_reg <= skid_reg;
         end
         if (load_skid_in) begin
            skid_pc  <= pc_in;
            skid_wb  <= wb_enable_in;
            skid_rs  <= rs_d_in;
            skid_reg <= reg_d_in;
         end
      end
   end

   assign pc_out        = head_pc;
   assign wb_enable_out = head_wb && valid_out;
   assign rs_d_out      = head_rs;
   assign reg_d_out     = head_reg;
   assign occupancy     = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance,
// each with its own driver, FIFO reference model and output monitor.
module tb_pipe_stage_skid;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic               wb;
      logic [RADDR_W-1:0] rs;
      logic [XLEN-1:0]    rd;
   } entry_t;

   bit clock;
   int n_tests = 0;
   int n_fail  = 0;
   bit summary_done = 0;

   initial forever #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic entry_t mk(input logic [XLEN-1:0] pc, input logic wb,
                                 input logic [RADDR_W-1:0] rs, input logic [XLEN-1:0] rd);
      entry_t e;
      e.pc = pc; e.wb = wb; e.rs = rs; e.rd = rd;
      return e;
   endfunction

   function automatic entry_t rnd();
      return mk($urandom, 1'($urandom), RADDR_W'($urandom), $urandom);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int S = (g == 0) ? 1 : 0;

      logic               reset = 1'b1;
      logic               flush = 1'b0;
      logic               valid_in = 1'b1;
      logic               ready_in = 1'b0;
      logic [XLEN-1:0]    pc_in = '1;
      logic               wb_enable_in = 1'b1;
      logic [RADDR_W-1:0] rs_d_in = '1;
      logic [XLEN-1:0]    reg_d_in = '1;
      logic               ready_out;
      logic               valid_out;
      logic [XLEN-1:0]    pc_out;
      logic               wb_enable_out;
      logic [RADDR_W-1:0] rs_d_out;
      logic [XLEN-1:0]    reg_d_out;
      logic [1:0]         occupancy;

      pipe_stage_skid #(.XLEN(XLEN), .RADDR_W(RADDR_W), .SKID(S)) dut (
         .clock(clock), .reset(reset), .flush(flush),
         .valid_in(valid_in), .ready_out(ready_out),
         .pc_in(pc_in), .wb_enable_in(wb_enable_in), .rs_d_in(rs_d_in), .reg_d_in(reg_d_in),
         .valid_out(valid_out), .ready_in(ready_in),
         .pc_out(pc_out), .wb_enable_out(wb_enable_out), .rs_d_out(rs_d_out),
         .reg_d_out(reg_d_out), .occupancy(occupancy)
      );

      // Reference model: the stage is a FIFO of capacity 2 (SKID=1) or 1
      // (SKID=0); "shown" is what the head fields display, which persists
      // after the FIFO empties and is zeroed only by reset.
      entry_t q[$];
      entry_t shown = '0;
      bit     done = 0;

      // One cycle of stimulus; the accepted entry is pushed to the scoreboard
      // just after the monitor has handled this cycle, i.e. at the edge.
      task automatic cyc(input bit v, input bit r, input bit f, input bit rst, input entry_t e);
         bit acc;
         @(posedge clock); #1;
         valid_in = v; ready_in = r; flush = f; reset = rst;
         pc_in = e.pc; wb_enable_in = e.wb; rs_d_in = e.rs; reg_d_in = e.rd;
         acc = v && !f && !rst && ((S != 0) ? (q.size() < 2) : (q.size() == 0 || r));
         @(negedge clock); #1;
         if (acc) q.push_back(e);
      endtask

      // Monitor: compare DUT outputs with the model, then retire the head.
      initial forever begin
         bit exp_valid;
         bit exp_ready;
         @(negedge clock);
         exp_valid = (q.size() != 0);
         if (exp_valid) shown = q[0];
         exp_ready = (S != 0) ? (q.size() < 2) : (!exp_valid || ready_in);
         check($sformatf("s%0d.valid_out", S), 64'(valid_out), 64'(exp_valid));
         check($sformatf("s%0d.ready_out", S), 64'(ready_out), 64'(exp_ready));
         check($sformatf("s%0d.occupancy", S), 64'(occupancy), 64'(q.size()));
         check($sformatf("s%0d.wb_enable_out", S), 64'(wb_enable_out), 64'(exp_valid && shown.wb));
         check($sformatf("s%0d.pc_out", S), 64'(pc_out), 64'(shown.pc));
         check($sformatf("s%0d.rs_d_out", S), 64'(rs_d_out), 64'(shown.rs));
         check($sformatf("s%0d.reg_d_out", S), 64'(reg_d_out), 64'(shown.rd));
         if (reset) begin
            q.delete();
            shown = '0;
         end else if (flush) begin
            q.delete();
         end else if (exp_valid && ready_in) begin
            void'(q.pop_front());
         end
      end

      // Driver: directed scenarios followed by a randomized phase.
      initial begin
         entry_t a = mk(32'h10, 1'b1, 5'd1, 32'h1111_0000);
         entry_t b = mk(32'h14, 1'b0, 5'd2, 32'h2222_0000);
         entry_t c = mk(32'h18, 1'b1, 5'd31, 32'hFFFF_FFFF);
         entry_t z = '0;
         // reset held with junk on the inputs, which must be ignored
         cyc(1, 1, 0, 1, rnd());
         cyc(1, 0, 1, 1, rnd());
         // single entry through an empty stage
         cyc(1, 1, 0, 0, mk(32'h100, 1'b1, 5'd3, 32'hDEAD_BEEF));
         cyc(0, 1, 0, 0, z);
         cyc(0, 1, 0, 0, z);
         // back-pressure with two entries, then release
         cyc(1, 0, 0, 0, a);
         cyc(1, 0, 0, 0, b);
         cyc(0, 0, 0, 0, z);
         cyc(0, 0, 0, 0, z);
         for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, z);
         // streaming: eight entries without a bubble
         for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, mk(32'(i * 4), 1'b1, 5'(i), 32'h8000_0000 | 32'(i)));
         for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, z);
         // flush while full, with a valid input in the flush cycle
         cyc(1, 0, 0, 0, a);
         cyc(1, 0, 0, 0, b);
         cyc(1, 0, 1, 0, c);
         for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, z);
         // reset while full
         cyc(1, 0, 0, 0, a);
         cyc(1, 0, 0, 0, b);
         cyc(1, 1, 0, 1, c);
         for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, z);
         // randomized traffic
         for (int i = 0; i < 700; i++)
            cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0,
                ($urandom % 100) == 0, rnd());
         for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, z);
         done = 1;
      end
   end

   initial begin
      wait (inst[0].done && inst[1].done);
      @(negedge clock);
      if (!summary_done) begin
         summary_done = 1;
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   initial begin
      #200000;
      if (!summary_done) begin
         summary_done = 1;
         n_tests++;
         n_fail++;
         $display("FAIL timeout: stimulus did not complete");
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

endmodule
